// File: rtl/max7219_spi_rx_if.sv
// SPI pin bundle between the face-matrix transmitter (master) and a passive listener (slave).
interface max7219_spi_rx_if;
  logic sclk_in;
  logic mosi_in;
  logic cs_in;

  modport master (output sclk_in, output mosi_in, output cs_in);
  modport slave  (input  sclk_in, input  mosi_in, input  cs_in);
endinterface

// File: rtl/max7219_spi_rx.sv
// Passive MAX7219 SPI frame decoder rebuilding the row/control register file from snooped traffic.
// frame_valid lands SYNC_STAGES+2 clk after cs pin rises; listen-only, no backpressure to the transmitter.
module max7219_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  max7219_spi_rx_if.slave       spi,
  input  logic [2:0]            row_sel,
  output logic [7:0]            row_data,
  output logic [7:0]            decode_mode,
  output logic [3:0]            intensity,
  output logic [2:0]            scan_limit,
  output logic                  shutdown_n,
  output logic                  display_test,
  output logic                  frame_valid,
  output logic [3:0]            frame_addr,
  output logic [7:0]            frame_data,
  output logic                  frame_err
);

  localparam int BW        = $clog2(FRAME_BITS + 1);
  localparam int FW        = $clog2(SYNC_STAGES + 1);
  // Only addr[3:0] and data survive a commit, so the upper nibble is never stored.
  localparam int KEEP_BITS = 12;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, cs_rise, cs_fall;
  logic [FW-1:0]          flush_cnt;
  logic                   armed;
  state_t                 state, state_nxt;
  logic                   start, shift_en, err_set, commit;
  logic [KEEP_BITS-1:0]   shreg;
  logic [BW-1:0]          bitcnt;
  logic [7:0]             rows [8];
  logic [3:0]             commit_addr;
  logic [7:0]             commit_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_in};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = armed & cs_prev & ~cs_s;

  // The chain resets to cs=1, so a cs held low through reset release would look like a fall;
  // only arm once the chain has flushed and the real pin has been seen high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else if (!armed) begin
      if (flush_cnt != FW'(SYNC_STAGES)) flush_cnt <= flush_cnt + 1'b1;
      else if (cs_s)                     armed     <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = (bitcnt == BW'(FRAME_BITS)) ? COMMIT : IDLE;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    shift_en = 1'b0;
    err_set  = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE:    start = cs_fall;
      SHIFT: begin
        shift_en = sclk_rise & ~cs_rise;
        err_set  = cs_rise & (bitcnt != BW'(FRAME_BITS));
      end
      COMMIT:  commit = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (start) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[KEEP_BITS-2:0], mosi_s};
      if (bitcnt != BW'(FRAME_BITS)) bitcnt <= bitcnt + 1'b1;
    end
  end

  assign commit_addr = shreg[11:8];
  assign commit_data = shreg[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rows[i] <= 8'h00;
      decode_mode  <= 8'h00;
      intensity    <= 4'h0;
      scan_limit   <= 3'h0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
      frame_addr   <= 4'h0;
      frame_data   <= 8'h00;
      row_data     <= 8'h00;
    end else begin
      frame_valid <= commit;
      frame_err   <= err_set;
      row_data    <= rows[row_sel];
      if (commit) begin
        frame_addr <= commit_addr;
        frame_data <= commit_data;
        case (commit_addr)
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: rows[3'(commit_addr - 4'd1)] <= commit_data;
          4'h9:    decode_mode  <= commit_data;
          4'hA:    intensity    <= commit_data[3:0];
          4'hB:    scan_limit   <= commit_data[2:0];
          4'hC:    shutdown_n   <= commit_data[0];
          4'hF:    display_test <= commit_data[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_max7219_spi_rx.sv
// Randomized bench for max7219_spi_rx against a frame-level register-file model.
module tb_max7219_spi_rx;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] row_sel;
  logic [7:0] row_data, decode_mode, frame_data;
  logic [3:0] intensity, frame_addr;
  logic [2:0] scan_limit;
  logic       shutdown_n, display_test, frame_valid, frame_err;

  max7219_spi_rx_if spi();

  max7219_spi_rx #(.SYNC_STAGES(SYNC), .FRAME_BITS(16)) dut (
    .clk(clk), .reset(reset), .spi(spi), .row_sel(row_sel), .row_data(row_data),
    .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
    .shutdown_n(shutdown_n), .display_test(display_test), .frame_valid(frame_valid),
    .frame_addr(frame_addr), .frame_data(frame_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int n_valid = 0, n_err = 0;
  int half = 4;

  logic [7:0] m_rows [8];
  logic [7:0] m_decode, m_fdata;
  logic [3:0] m_int, m_faddr;
  logic [2:0] m_scan;
  logic       m_shut, m_dtest;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_valid) n_valid++;
      if (frame_err)   n_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_rows[i] = 8'h00;
    m_decode = 8'h00; m_int = 4'h0; m_scan = 3'h0; m_shut = 1'b0; m_dtest = 1'b0;
    m_faddr = 4'h0; m_fdata = 8'h00;
  endfunction

  function automatic void model_commit(input logic [15:0] f);
    int a;
    a = int'(f[11:8]);
    m_faddr = f[11:8];
    m_fdata = f[7:0];
    if (a >= 1 && a <= 8) m_rows[a-1] = f[7:0];
    else if (a == 9)  m_decode = f[7:0];
    else if (a == 10) m_int    = f[3:0];
    else if (a == 11) m_scan   = f[2:0];
    else if (a == 12) m_shut   = f[0];
    else if (a == 15) m_dtest  = f[0];
  endfunction

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      row_sel = 3'(r);
      @(posedge clk); #1;
      check($sformatf("%s row%0d", tag, r), row_data, m_rows[r]);
    end
    check({tag, " decode_mode"},  decode_mode,  m_decode);
    check({tag, " intensity"},    intensity,    m_int);
    check({tag, " scan_limit"},   scan_limit,   m_scan);
    check({tag, " shutdown_n"},   shutdown_n,   m_shut);
    check({tag, " display_test"}, display_test, m_dtest);
    check({tag, " frame_addr"},   frame_addr,   m_faddr);
    check({tag, " frame_data"},   frame_data,   m_fdata);
  endtask

  task automatic do_reset(input logic cs_level);
    @(negedge clk);
    reset = 1'b1;
    spi.cs_in = cs_level; spi.sclk_in = 1'b0; spi.mosi_in = 1'b0;
    hold(3);
    reset = 1'b0;
    model_reset();
    hold(SYNC + 4);
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi.cs_in = 1'b0; spi.sclk_in = 1'b0;
    hold(half);
  endtask

  // Sends the low nbits of val MSB first; returns at a negedge with sclk low.
  task automatic sclk_bits(input logic [63:0] val, input int nbits);
    @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi.sclk_in = 1'b0; spi.mosi_in = val[i];
      hold(half);
      spi.sclk_in = 1'b1;
      hold(half);
    end
    spi.sclk_in = 1'b0;
    hold(half);
  endtask

  task automatic spi_tx(input string tag, input logic [63:0] val, input int nbits);
    int v0, e0, lat;
    v0 = n_valid; e0 = n_err; lat = 0;
    cs_low();
    sclk_bits(val, nbits);
    spi.cs_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (frame_valid && lat == 0) lat = k;
    end
    @(negedge clk);
    if (nbits >= 16) begin
      model_commit(val[15:0]);
      check({tag, " latency"},     lat,          SYNC + 2);
      check({tag, " valid_count"}, n_valid - v0, 1);
      check({tag, " err_count"},   n_err - e0,   0);
      check({tag, " frame_addr"},  frame_addr,   m_faddr);
      check({tag, " frame_data"},  frame_data,   m_fdata);
    end else begin
      check({tag, " valid_count"}, n_valid - v0, 0);
      check({tag, " err_count"},   n_err - e0,   1);
    end
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2_data [8];
    int v0, e0, nb;
    logic [63:0] rv;
    t2_data = '{8'h3C, 8'h5A, 8'hA5, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'hFF};
    reset = 1'b1; row_sel = 3'd0;
    spi.cs_in = 1'b1; spi.sclk_in = 1'b0; spi.mosi_in = 1'b0;
    model_reset();
    do_reset(1'b1);
    check("reset frame_valid", frame_valid, 0);
    check("reset frame_err",   frame_err,   0);
    check_regs("reset");

    half = 4;
    spi_tx("T1", 64'h0C01, 16);
    check("T1 shutdown_n", shutdown_n, 1);

    for (int r = 0; r < 8; r++)
      spi_tx($sformatf("T2 row%0d", r), {48'h0, 4'h0, 4'(r + 1), t2_data[r]}, 16);
    spi_tx("T2 int", 64'h0A1F, 16);
    check_regs("T2");

    spi_tx("T3", 64'h0BAD, 12);
    check_regs("T3");

    spi_tx("T4", 64'hABCD_0355, 32);
    check_regs("T4");

    // Partial frame cut short by reset must leave no trace.
    v0 = n_valid; e0 = n_err;
    cs_low();
    sclk_bits(64'h0477 >> 7, 9);
    do_reset(1'b1);
    check("T5 err_after_reset", n_err - e0, 0);
    check("T5 valid_after_reset", n_valid - v0, 0);
    spi_tx("T5", 64'h0466, 16);
    check_regs("T5");

    model_commit(16'h0000);
    do_reset(1'b0);
    v0 = n_valid; e0 = n_err;
    sclk_bits(64'h0155, 16);
    spi.cs_in = 1'b1;
    hold(12);
    check("T6 valid_count", n_valid - v0, 0);
    check("T6 err_count",   n_err - e0,   0);
    check_regs("T6");
    spi_tx("T6 next", 64'h0912, 16);

    for (int n = 0; n < 40; n++) begin
      half = int'($urandom_range(3, 6));
      rv = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       nb = int'($urandom_range(1, 15));
        1:       nb = int'($urandom_range(17, 40));
        default: nb = 16;
      endcase
      spi_tx($sformatf("rnd%0d", n), rv, nb);
      if (n % 4 == 3) check_regs($sformatf("rnd%0d", n));
    end
    check_regs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
